mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, SHALL set the consecutive fetch-denial cycles before fetch gets forced priority (legal 1..15).
REQ-002 clk  input  1  single clock for the block; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be synchronous and active-high.
REQ-004 if_req  input  1  fetch read request; SHALL be held until if_valid.
REQ-005 if_addr  input  32  fetch address.
REQ-006 if_flush  input  1  branch squash; SHALL discard the fetch response in its cycle.
REQ-007 if_rdata  output  32  fetch read data; if_valid  output  1  fetch response strobe.
REQ-008 dm_req  input  1  data request; dm_we  input  1  1=write, 0=read.
REQ-009 dm_addr, dm_wdata  input  32 each  data address and write data.
REQ-010 dm_rdata  output  32  data read data; dm_valid  output  1  data response/write-ack strobe.
REQ-011 if_stall, dm_stall  output  1 each  pipeline hold = req AND NOT granted this cycle.
REQ-012 ram_cs, ram_oe, ram_we  output  1 each; ram_addr, ram_din  output  32 each; ram_dout  input  32  single-port syncram interface.

Function
REQ-013 Arbiter SHALL grant at most one requester per cycle; the grant SHALL be combinational from current requests and registered state.
REQ-014 Default priority SHALL be data over fetch.
REQ-015 A 4-bit starve counter SHALL increment each cycle if_req is asserted and not granted, and SHALL clear on fetch grant or when if_req is low.
REQ-016 When starve counter equals STARVE_MAX, fetch SHALL win that cycle even if dm_req is asserted.
REQ-017 On a grant, ram_cs=1, ram_addr=winner address; data write drives ram_we=1, ram_oe=0, ram_din=dm_wdata; any read drives ram_we=0, ram_oe=1.
REQ-018 With no grant, ram_cs, ram_oe and ram_we SHALL be 0; ram_addr and ram_din SHALL be 0.
REQ-019 A registered response-owner FSM SHALL have states IDLE, IF_RESP, DM_RESP; grant to fetch -> IF_RESP, grant to data -> DM_RESP, no grant -> IDLE, evaluated every cycle.
REQ-020 Latency SHALL be one cycle: request granted in cycle N gives its valid strobe in cycle N+1 with rdata = ram_dout.
REQ-021 Back-to-back grants SHALL be allowed, giving one access per cycle throughput.
REQ-022 In IF_RESP, if_valid SHALL be 1 unless if_flush=1 in that cycle, in which case if_valid SHALL be 0.
REQ-023 In DM_RESP, dm_valid SHALL be 1; for writes dm_rdata SHALL be 0.
REQ-024 A requester SHALL NOT be re-granted the same request in the same cycle its valid is asserted unless its req is still high; a held req after valid is treated as a new request.
REQ-025 if_rdata and dm_rdata SHALL be 0 when the corresponding valid is 0.
REQ-026 Simultaneous if_req and dm_req with counter below STARVE_MAX: data granted, if_stall=1, dm_stall=0.

Reset
REQ-027 On reset: FSM = IDLE, starve counter = 0, all valid, stall and ram control outputs = 0 in the following cycle.
REQ-028 Reset asserted with a response pending SHALL drop that response; no valid strobe SHALL appear.

Structure
REQ-029 FSM state encodings and the counter width constant SHALL live in the shared package mem_arb_pkg.
REQ-030 Starve counter SHALL be a sub-module starve_counter (inc, clr, saturate at 15, terminal-match output).

Verification
REQ-031 Fetch-only read of 0x10 with RAM word 0xDEADBEEF -> grant cycle N, if_valid=1 and if_rdata=0xDEADBEEF in N+1, if_stall=0.
REQ-032 Simultaneous fetch 0x20 and data write 0x40 = 0x12345678 -> N: ram_we=1, addr 0x40, if_stall=1; N+1: dm_valid=1, fetch granted; N+2: if_valid=1.
REQ-033 dm_req held high for 10 cycles with if_req held, STARVE_MAX=4 -> fetch granted on the 5th cycle, data stalled that cycle only.
REQ-034 Fetch granted in N with if_flush=1 in N+1 -> if_valid=0 in N+1, no later fetch response.
REQ-035 Data read granted, reset asserted in N+1 -> dm_valid=0 in N+1 and N+2, FSM IDLE, counter 0.
REQ-036 No requests for 5 cycles -> ram_cs=0, both valids 0, both stalls 0 every cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Holds the response-owner FSM encoding and the starve counter width.
package mem_arb_pkg;

    localparam int unsigned CntWidth = 4;
    localparam logic [CntWidth-1:0] CntMax = '1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StIfResp = 2'd1,
        StDmResp = 2'd2
    } resp_state_e;

endpackage

// File: rtl/starve_counter.sv
// Saturating fetch-denial counter; match flags the cycle fetch must be forced through.
module starve_counter
    import mem_arb_pkg::*;
#(
    parameter int unsigned Terminal = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic match
);

    logic [CntWidth-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != CntMax)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign match = (count_q == CntWidth'(Terminal));

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a single-port synchronous RAM.
// Data wins by default; a starved fetch is forced through once the denial count hits STARVE_MAX.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_valid,
    output logic        if_stall,
    output logic        dm_stall,
    output logic        ram_cs,
    output logic        ram_oe,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout
);

    resp_state_e state_q, state_d;
    logic        we_q, we_d;
    logic        if_grant, dm_grant;
    logic        starve_hit;

    starve_counter #(
        .Terminal(STARVE_MAX)
    ) u_starve (
        .clk  (clk),
        .reset(reset),
        .inc  (if_req && !if_grant),
        .clr  (if_grant || !if_req),
        .match(starve_hit)
    );

    // No grants while reset is held so nothing reaches the RAM or the response FSM.
    always_comb begin
        if_grant = 1'b0;
        dm_grant = 1'b0;
        if (!reset) begin
            if (if_req && (starve_hit || !dm_req)) begin
                if_grant = 1'b1;
            end else if (dm_req) begin
                dm_grant = 1'b1;
            end
        end
    end

    assign if_stall = if_req && !if_grant && !reset;
    assign dm_stall = dm_req && !dm_grant && !reset;

    always_comb begin
        ram_cs   = 1'b0;
        ram_oe   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (if_grant) begin
            ram_cs   = 1'b1;
            ram_oe   = 1'b1;
            ram_addr = if_addr;
        end else if (dm_grant) begin
            ram_cs   = 1'b1;
            ram_we   = dm_we;
            ram_oe   = !dm_we;
            ram_addr = dm_addr;
            ram_din  = dm_we ? dm_wdata : '0;
        end
    end

    always_comb begin
        state_d = StIdle;
        we_d    = 1'b0;
        if (if_grant) begin
            state_d = StIfResp;
        end else if (dm_grant) begin
            state_d = StDmResp;
            we_d    = dm_we;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
        end
    end

    // Reset in the response cycle drops the pending strobe.
    always_comb begin
        if_valid = (state_q == StIfResp) && !if_flush && !reset;
        dm_valid = (state_q == StDmResp) && !reset;
        if_rdata = if_valid ? ram_dout : '0;
        dm_rdata = (dm_valid && !we_q) ? ram_dout : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-level reference model with its own RAM image.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_flush, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [31:0] if_rdata, dm_rdata, ram_addr, ram_din;
    logic        if_valid, dm_valid, if_stall, dm_stall, ram_cs, ram_oe, ram_we;
    logic [31:0] ram_dout;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .if_req  (if_req),
        .if_addr (if_addr),
        .if_flush(if_flush),
        .if_rdata(if_rdata),
        .if_valid(if_valid),
        .dm_req  (dm_req),
        .dm_we   (dm_we),
        .dm_addr (dm_addr),
        .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata),
        .dm_valid(dm_valid),
        .if_stall(if_stall),
        .dm_stall(dm_stall),
        .ram_cs  (ram_cs),
        .ram_oe  (ram_oe),
        .ram_we  (ram_we),
        .ram_addr(ram_addr),
        .ram_din (ram_din),
        .ram_dout(ram_dout)
    );

    function automatic logic [31:0] init_word(int idx);
        logic [31:0] w;
        if (idx == 4) return 32'hDEADBEEF;
        w = 32'h1000_0000 + 32'(idx) * 32'h0001_0003;
        return w;
    endfunction

    // Synchronous single-port RAM, word-indexed over the low 1 KiB.
    bit [31:0] ram_mem [256];
    bit        ram_wr  [256];
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) begin
                ram_mem[ram_addr[9:2]] <= ram_din;
                ram_wr[ram_addr[9:2]]  <= 1'b1;
            end else if (ram_oe) begin
                ram_dout <= ram_wr[ram_addr[9:2]] ? ram_mem[ram_addr[9:2]]
                                                  : init_word(int'(ram_addr[9:2]));
            end
        end
    end

    // Reference model state: denial count, pending response owner (0 none, 1 fetch, 2 data).
    bit [31:0]   model_mem [256];
    bit          model_wr  [256];
    int          m_starve = 0;
    int          m_pend   = 0;
    bit          m_pend_we;
    logic [31:0] m_pend_data;
    int          cur_who;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Settle mid-cycle, predict the winner and compare every output with the model.
    task automatic eval();
        int          who;
        logic [31:0] e_addr, e_din, e_ifd, e_dmd;
        logic        e_ifv, e_dmv;
        #3;
        who = 0;
        if (!reset) begin
            if (if_req && (m_starve == STARVE_MAX || !dm_req)) who = 1;
            else if (dm_req) who = 2;
        end
        e_addr = (who == 1) ? if_addr : (who == 2) ? dm_addr : 32'h0;
        e_din  = (who == 2 && dm_we) ? dm_wdata : 32'h0;
        check("ram_cs", {31'b0, ram_cs}, {31'b0, who != 0});
        check("ram_we", {31'b0, ram_we}, {31'b0, who == 2 && dm_we});
        check("ram_oe", {31'b0, ram_oe}, {31'b0, who == 1 || (who == 2 && !dm_we)});
        check("ram_addr", ram_addr, e_addr);
        check("ram_din", ram_din, e_din);
        check("if_stall", {31'b0, if_stall}, {31'b0, !reset && if_req && who != 1});
        check("dm_stall", {31'b0, dm_stall}, {31'b0, !reset && dm_req && who != 2});
        e_ifv = !reset && m_pend == 1 && !if_flush;
        e_dmv = !reset && m_pend == 2;
        e_ifd = e_ifv ? m_pend_data : 32'h0;
        e_dmd = (e_dmv && !m_pend_we) ? m_pend_data : 32'h0;
        check("if_valid", {31'b0, if_valid}, {31'b0, e_ifv});
        check("dm_valid", {31'b0, dm_valid}, {31'b0, e_dmv});
        check("if_rdata", if_rdata, e_ifd);
        check("dm_rdata", dm_rdata, e_dmd);
        cur_who = who;
    endtask

    task automatic advance();
        logic [31:0] a;
        int          idx;
        if (reset) begin
            m_starve = 0;
            m_pend   = 0;
        end else begin
            m_pend    = cur_who;
            m_pend_we = (cur_who == 2) && dm_we;
            if (cur_who != 0) begin
                a   = (cur_who == 1) ? if_addr : dm_addr;
                idx = int'(a[9:2]);
                if (m_pend_we) begin
                    model_mem[idx] = dm_wdata;
                    model_wr[idx]  = 1'b1;
                    m_pend_data    = 32'h0;
                end else begin
                    m_pend_data = model_wr[idx] ? model_mem[idx] : init_word(idx);
                end
            end
            if (if_req && cur_who != 1) m_starve = (m_starve < 15) ? m_starve + 1 : 15;
            else m_starve = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 0; if_flush = 0; dm_req = 0; dm_we = 0;
        if_addr = 0; dm_addr = 0; dm_wdata = 0;
    endtask

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic        e_if_stall;
        logic        e_dm_stall;
        logic        e_cs;
        logic        e_we;
        logic        e_oe;
        logic [31:0] e_addr;
        logic [31:0] e_din;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{1, 32'h100, 0, 0, 32'h0,   32'h0,        0, 0, 1, 0, 1, 32'h100, 32'h0};
        vecs[1] = '{0, 32'h0,   1, 0, 32'h200, 32'h0,        0, 0, 1, 0, 1, 32'h200, 32'h0};
        vecs[2] = '{0, 32'h0,   1, 1, 32'h204, 32'hCAFEF00D, 0, 0, 1, 1, 0, 32'h204,
                    32'hCAFEF00D};
        vecs[3] = '{1, 32'h10C, 1, 0, 32'h208, 32'h0,        1, 0, 1, 0, 1, 32'h208, 32'h0};
        vecs[4] = '{1, 32'h0C0, 1, 1, 32'h030, 32'h55AA,     1, 0, 1, 1, 0, 32'h030,
                    32'h55AA};
        vecs[5] = '{0, 32'h0,   0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 0, 32'h0,   32'h0};

        idle_inputs();
        reset = 1;
        @(posedge clk); #1;
        eval(); advance();
        eval(); advance();
        reset = 0;
        eval();
        check("rst_state", {30'b0, dut.state_q}, {30'b0, StIdle});
        check("rst_count", {28'b0, dut.u_starve.count_q}, 32'h0);
        advance();

        // Vector table, each entry followed by an idle cycle to clear the counter.
        for (int i = 0; i < 6; i++) begin
            if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
            dm_req = vecs[i].dm_req; dm_we = vecs[i].dm_we;
            dm_addr = vecs[i].dm_addr; dm_wdata = vecs[i].dm_wdata;
            eval();
            check("vec_if_stall", {31'b0, if_stall}, {31'b0, vecs[i].e_if_stall});
            check("vec_dm_stall", {31'b0, dm_stall}, {31'b0, vecs[i].e_dm_stall});
            check("vec_cs", {31'b0, ram_cs}, {31'b0, vecs[i].e_cs});
            check("vec_we", {31'b0, ram_we}, {31'b0, vecs[i].e_we});
            check("vec_oe", {31'b0, ram_oe}, {31'b0, vecs[i].e_oe});
            check("vec_addr", ram_addr, vecs[i].e_addr);
            check("vec_din", ram_din, vecs[i].e_din);
            advance();
            idle_inputs();
            eval(); advance();
        end

        // Fetch-only read of 0x10.
        if_req = 1; if_addr = 32'h10;
        eval();
        check("f_only_stall", {31'b0, if_stall}, 32'h0);
        check("f_only_addr", ram_addr, 32'h10);
        advance();
        if_req = 0;
        eval();
        check("f_only_valid", {31'b0, if_valid}, 32'h1);
        check("f_only_rdata", if_rdata, 32'hDEADBEEF);
        advance();

        // Simultaneous fetch and data write.
        if_req = 1; if_addr = 32'h20; dm_req = 1; dm_we = 1; dm_addr = 32'h40;
        dm_wdata = 32'h12345678;
        eval();
        check("sim_we", {31'b0, ram_we}, 32'h1);
        check("sim_addr", ram_addr, 32'h40);
        check("sim_if_stall", {31'b0, if_stall}, 32'h1);
        advance();
        dm_req = 0; dm_we = 0;
        eval();
        check("sim_dm_valid", {31'b0, dm_valid}, 32'h1);
        check("sim_dm_rdata", dm_rdata, 32'h0);
        check("sim_f_grant", ram_addr, 32'h20);
        advance();
        if_req = 0;
        eval();
        check("sim_if_valid", {31'b0, if_valid}, 32'h1);
        check("sim_if_rdata", if_rdata, init_word(8));
        advance();

        // Starvation: both held for 10 cycles; fetch forced after four denials.
        idle_inputs();
        eval(); advance();
        if_req = 1; if_addr = 32'h84; dm_req = 1; dm_addr = 32'h80;
        for (int k = 1; k <= 10; k++) begin
            eval();
            check("starve_dm_stall", {31'b0, dm_stall}, {31'b0, k == 5 || k == 10});
            check("starve_if_stall", {31'b0, if_stall}, {31'b0, !(k == 5 || k == 10)});
            if (k == 5) check("starve_addr", ram_addr, 32'h84);
            advance();
        end

        // Flush in the response cycle squashes the fetch response.
        idle_inputs();
        eval(); advance();
        if_req = 1; if_addr = 32'h10;
        eval(); advance();
        if_req = 0; if_flush = 1;
        eval();
        check("flush_valid", {31'b0, if_valid}, 32'h0);
        check("flush_rdata", if_rdata, 32'h0);
        advance();
        if_flush = 0;
        for (int k = 0; k < 2; k++) begin
            eval();
            check("flush_late", {31'b0, if_valid}, 32'h0);
            advance();
        end

        // Reset in the response cycle drops the data response.
        dm_req = 1; dm_addr = 32'h50; if_req = 1; if_addr = 32'h54;
        eval(); advance();
        dm_req = 0; reset = 1;
        eval();
        check("rst_dm_valid1", {31'b0, dm_valid}, 32'h0);
        advance();
        reset = 0; if_req = 0;
        eval();
        check("rst_dm_valid2", {31'b0, dm_valid}, 32'h0);
        check("rst_fsm_idle", {30'b0, dm_state()}, {30'b0, StIdle});
        check("rst_count0", {28'b0, dut.u_starve.count_q}, 32'h0);
        advance();

        // Quiet period.
        for (int k = 0; k < 5; k++) begin
            eval();
            check("quiet", {27'b0, ram_cs, if_valid, dm_valid, if_stall, dm_stall}, 32'h0);
            advance();
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            reset    = ($urandom_range(0, 39) == 0);
            if_req   = $urandom_range(0, 1) == 1;
            dm_req   = $urandom_range(0, 2) != 0;
            dm_we    = $urandom_range(0, 1) == 1;
            if_flush = ($urandom_range(0, 5) == 0);
            if_addr  = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
            dm_addr  = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
            dm_wdata = $urandom;
            eval(); advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    function automatic logic [1:0] dm_state();
        return dut.state_q;
    endfunction

endmodule
